fft_sdf_bf_stage: RTL and testbench
===================================

Name: fft_sdf_bf_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage, first stage of the 16-point streaming FFT.
- Consumes the state code and twiddle pair (w_r/w_i) from the twiddle ROM in the same cycle as the input sample.
- Output stream feeds the next FFT stage.
- Holds a DEPTH-entry feedback delay line, a complex add/subtract, and a complex twiddle multiplier with rounding.

Parameters:
- DW, 24, data/twiddle word width, signed two's complement
- FRAC, 8, fractional bits of twiddle (1.0 = 256)
- DEPTH, 8, feedback delay-line length (N/2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  din_r/din_i/state/w_r/w_i valid this cycle
- flush  in  1  advance with zero input; drains the last frame
- din_r  in  DW  input sample, real
- din_i  in  DW  input sample, imaginary
- state  in  2  0 = fill, 1 = butterfly, 2 = twiddle, 3 = treated as 0
- w_r  in  DW  twiddle, real
- w_i  in  DW  twiddle, imaginary
- out_valid  out  1  dout valid
- dout_r  out  DW  output sample, real
- dout_i  out  DW  output sample, imaginary

Behaviour:
- Reset (reset=0, async):
  - out_valid=0, dout_r=dout_i=0.
  - All DEPTH delay entries = 0; write pointer ptr = 0.
  - Reset mid-frame discards all partial data. The first post-reset frame starts in fill.
- Advance: adv = in_valid | flush. No adv → all registers hold; out_valid=0 next cycle.
- Input selection:
  - in = din when in_valid=1.
  - in = 0 when flush=1 and in_valid=0.
  - in_valid has priority over flush.
- Delay line is circular. On adv: head = mem[ptr]; mem[ptr] <= push; ptr <= ptr+1 mod DEPTH.
- Action per state on adv:
  - state 0/3 (fill): push = in; out_valid <= 0; dout holds.
  - state 1 (butterfly): push = head - in; dout <= head + in; out_valid <= 1.
  - state 2 (twiddle): push = in; dout <= head * w; out_valid <= 1.
- Add/sub arithmetic:
  - Performed at DW+1 bits, then reduced to DW (wrap or saturate, see Optional Feature).
  - Real and imaginary parts are handled independently.
- Complex multiply:
  - pr = head_r*w_r - head_i*w_i; pi = head_r*w_i + head_i*w_r; 2*DW+1-bit signed.
  - Round half up: add 2^(FRAC-1), arithmetic shift right FRAC, reduce to DW.
- Latency: exactly 1 cycle from the adv sampling edge to dout/out_valid. Fully registered outputs; no combinational path from inputs to outputs.
- Throughput: one sample per clock, no stalls. The upstream ROM sequencing (8 fill, then alternating 8 butterfly / 8 twiddle) is trusted and not checked.
- flush in state 1 performs butterflies against zero. flush in state 2 drains the stored differences.
- ptr wrap: entry 7 is followed by entry 0. A state change at the wrap boundary needs no special handling.

Optional Feature:
- Macro: FFT_SDF_SAT_EN.
- Defined: add/sub and rounded multiply results saturate to [-2^(DW-1), 2^(DW-1)-1].
- Undefined: results are truncated to the low DW bits (two's-complement wrap).
- Port list is identical in both builds.

Test Plan:
- Reset and hold: reset=0 mid-stream, then release with in_valid=0 for 5 cycles → out_valid=0, dout=0, delay line reads back 0.
- Ramp frame:
  - Stimulus: din_r = n*256, din_i = 0, n = 0..15; 8 cycles state 0 then 8 cycles state 1; unit twiddle.
  - Required: out_valid rises 1 cycle after the first state-1 sample.
  - Required: dout_r = (2k+8)*256 for k = 0..7 (2048, 2560, ... 5632); dout_i = 0.
- Twiddle phase:
  - Stimulus: continue with 8 cycles state 2; ROM twiddles k=0: (256,0), k=2: (181,-181), k=4: (0,-256).
  - Required: k=0 → dout = (0xFFF800, 0); k=2 → (-1448, +1448); k=4 → (0, +2048).
- Rounding: head = (1,0), w = (128,0) in state 2 → dout_r = 1. head = (-1,0), same w → dout_r = 0.
- Overflow:
  - Stimulus: head_r = 0x7FFFFF, din_r = 0x7FFFFF in state 1.
  - Required: dout_r = 0xFFFFFE without FFT_SDF_SAT_EN; 0x7FFFFF with it.
- Gaps and flush:
  - Stimulus: ramp frame with in_valid deasserted 3 cycles mid-frame, then flush for 8 state-2 cycles.
  - Required: outputs identical to the gap-free run; no out_valid during gaps.

Source files
------------

// File: rtl/fft_sdf_bf_stage_if.sv
// Streaming sample/twiddle bus into and out of one radix-2 SDF butterfly stage.
interface fft_sdf_bf_stage_if #(
  parameter int unsigned DW = 24
);
  logic          in_valid;
  logic          flush;
  logic [DW-1:0] din_r;
  logic [DW-1:0] din_i;
  logic [1:0]    state;
  logic [DW-1:0] w_r;
  logic [DW-1:0] w_i;
  logic          out_valid;
  logic [DW-1:0] dout_r;
  logic [DW-1:0] dout_i;

  modport master (
    output in_valid, flush, din_r, din_i, state, w_r, w_i,
    input  out_valid, dout_r, dout_i
  );

  modport slave (
    input  in_valid, flush, din_r, din_i, state, w_r, w_i,
    output out_valid, dout_r, dout_i
  );
endinterface

// File: rtl/fft_sdf_bf_stage.sv
// Radix-2 SDF butterfly stage: circular feedback delay line, complex add/sub, rounded twiddle
// multiply. Define FFT_SDF_SAT_EN to saturate results instead of wrapping.
module fft_sdf_bf_stage #(
  parameter int unsigned DW    = 24,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned DEPTH = 8
) (
  input logic               clk,
  input logic               reset,
  fft_sdf_bf_stage_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned XW = 2 * DW + 1;

  typedef logic signed [XW-1:0] wide_t;

  localparam wide_t RndBias = wide_t'(1) <<< (FRAC - 1);

`ifdef FFT_SDF_SAT_EN
  localparam wide_t SatMax = {{(DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam wide_t SatMin = {{(DW + 2){1'b1}}, {(DW - 1){1'b0}}};

  function automatic logic [DW-1:0] reduce(input wide_t v);
    if (v > SatMax) return SatMax[DW-1:0];
    if (v < SatMin) return SatMin[DW-1:0];
    return v[DW-1:0];
  endfunction
`else
  function automatic logic [DW-1:0] reduce(input wide_t v);
    logic unused_hi;
    unused_hi = ^v[XW-1:DW];
    return v[DW-1:0];
  endfunction
`endif

  logic [DW-1:0] mem_r_q [DEPTH];
  logic [DW-1:0] mem_i_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] dout_r_q, dout_r_d, dout_i_q, dout_i_d;
  logic [DW-1:0] push_r, push_i;

  logic                   adv;
  logic signed [DW-1:0]   in_r, in_i, head_r, head_i;
  logic signed [DW:0]     sum_r, sum_i, dif_r, dif_i;
  logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;
  wide_t                  prod_r, prod_i;

  // in_valid wins over flush; a flush-only advance feeds zeros.
  assign adv  = bus.in_valid | bus.flush;
  assign in_r = bus.in_valid ? $signed(bus.din_r) : '0;
  assign in_i = bus.in_valid ? $signed(bus.din_i) : '0;

  assign head_r = $signed(mem_r_q[ptr_q]);
  assign head_i = $signed(mem_i_q[ptr_q]);

  assign sum_r = {head_r[DW-1], head_r} + {in_r[DW-1], in_r};
  assign sum_i = {head_i[DW-1], head_i} + {in_i[DW-1], in_i};
  assign dif_r = {head_r[DW-1], head_r} - {in_r[DW-1], in_r};
  assign dif_i = {head_i[DW-1], head_i} - {in_i[DW-1], in_i};

  assign p_rr = head_r * $signed(bus.w_r);
  assign p_ii = head_i * $signed(bus.w_i);
  assign p_ri = head_r * $signed(bus.w_i);
  assign p_ir = head_i * $signed(bus.w_r);

  // Round half up: bias then arithmetic shift floors toward -inf.
  assign prod_r = (wide_t'(p_rr) - wide_t'(p_ii) + RndBias) >>> FRAC;
  assign prod_i = (wide_t'(p_ri) + wide_t'(p_ir) + RndBias) >>> FRAC;

  assign ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    push_r      = in_r;
    push_i      = in_i;
    out_valid_d = 1'b0;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    if (adv) begin
      case (bus.state)
        2'd1: begin
          push_r      = reduce(wide_t'(dif_r));
          push_i      = reduce(wide_t'(dif_i));
          dout_r_d    = reduce(wide_t'(sum_r));
          dout_i_d    = reduce(wide_t'(sum_i));
          out_valid_d = 1'b1;
        end
        2'd2: begin
          dout_r_d    = reduce(prod_r);
          dout_i_d    = reduce(prod_i);
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r_q[i] <= '0;
        mem_i_q[i] <= '0;
      end
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (adv) begin
        mem_r_q[ptr_q] <= push_r;
        mem_i_q[ptr_q] <= push_i;
        ptr_q          <= ptr_d;
        dout_r_q       <= dout_r_d;
        dout_i_q       <= dout_i_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout_r    = dout_r_q;
  assign bus.dout_i    = dout_i_q;
endmodule

// File: tb/tb_fft_sdf_bf_stage.sv
// Self-checking bench for fft_sdf_bf_stage: directed frame tables, corner sequences and a
// queue-based reference model under random traffic.
module tb_fft_sdf_bf_stage;
  localparam int DW    = 24;
  localparam int FRAC  = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_sdf_bf_stage_if #(.DW(DW)) bus ();

  fft_sdf_bf_stage #(
    .DW   (DW),
    .FRAC (FRAC),
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the delay line is a FIFO of DEPTH complex words.
  longint mq_r[$];
  longint mq_i[$];
  longint exp_v, exp_r, exp_i;

  typedef struct {
    bit         iv;
    bit         fl;
    logic [1:0] st;
    int         dr;
    int         di;
    int         wr;
    int         wi;
    bit         ev;
    bit         cd;
    int         er;
    int         ei;
  } vec_t;

  vec_t tbl[24];

  function automatic longint red(input longint v);
    longint lim;
    lim = longint'(1) <<< (DW - 1);
`ifdef FFT_SDF_SAT_EN
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
`else
    begin
      longint m;
      m = v & ((longint'(1) <<< DW) - 1);
      if (m >= lim) m = m - (longint'(1) <<< DW);
      return m;
    end
`endif
  endfunction

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    mq_r.delete();
    mq_i.delete();
    for (int i = 0; i < DEPTH; i++) begin
      mq_r.push_back(0);
      mq_i.push_back(0);
    end
    exp_v = 0;
    exp_r = 0;
    exp_i = 0;
  endtask

  task automatic model_step(input bit iv, input bit fl, input logic [1:0] st,
                            input longint dr, input longint di, input longint wr,
                            input longint wi);
    longint ir, ii, hr, hi;
    if (!(iv || fl)) begin
      exp_v = 0;
      return;
    end
    ir = iv ? dr : 0;
    ii = iv ? di : 0;
    hr = mq_r.pop_front();
    hi = mq_i.pop_front();
    case (st)
      2'd1: begin
        mq_r.push_back(red(hr - ir));
        mq_i.push_back(red(hi - ii));
        exp_r = red(hr + ir);
        exp_i = red(hi + ii);
        exp_v = 1;
      end
      2'd2: begin
        mq_r.push_back(ir);
        mq_i.push_back(ii);
        exp_r = red((hr * wr - hi * wi + (longint'(1) <<< (FRAC - 1))) >>> FRAC);
        exp_i = red((hr * wi + hi * wr + (longint'(1) <<< (FRAC - 1))) >>> FRAC);
        exp_v = 1;
      end
      default: begin
        mq_r.push_back(ir);
        mq_i.push_back(ii);
        exp_v = 0;
      end
    endcase
  endtask

  // One clock: apply inputs, step past the edge, advance the model.
  task automatic drive(input bit iv, input bit fl, input logic [1:0] st, input longint dr,
                       input longint di, input longint wr, input longint wi);
    bus.in_valid = iv;
    bus.flush    = fl;
    bus.state    = st;
    bus.din_r    = DW'(dr);
    bus.din_i    = DW'(di);
    bus.w_r      = DW'(wr);
    bus.w_i      = DW'(wi);
    @(posedge clk);
    #1;
    model_step(iv, fl, st, sx(DW'(dr)), sx(DW'(di)), sx(DW'(wr)), sx(DW'(wi)));
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_valid"}, longint'(bus.out_valid), exp_v);
    chk({tag, "_dout_r"}, sx(bus.dout_r), exp_r);
    chk({tag, "_dout_i"}, sx(bus.dout_i), exp_i);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    chk({tag, "_async_valid"}, longint'(bus.out_valid), 0);
    chk({tag, "_async_dout_r"}, sx(bus.dout_r), 0);
    chk({tag, "_async_dout_i"}, sx(bus.dout_i), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic run_table(input bit gaps, input string tag);
    for (int i = 0; i < 24; i++) begin
      bit iv, fl;
      if (gaps && i == 12) begin
        for (int g = 0; g < 3; g++) begin
          drive_idle();
          chk($sformatf("%s_gap%0d_valid", tag, g), longint'(bus.out_valid), 0);
        end
      end
      iv = tbl[i].iv;
      fl = tbl[i].fl;
      // Drain variant: twiddle phase runs on flush alone with garbage on din.
      if (gaps && i >= 16) begin
        iv = 1'b0;
        fl = 1'b1;
        drive(iv, fl, tbl[i].st, 'h123456, 'h654321, tbl[i].wr, tbl[i].wi);
      end else begin
        drive(iv, fl, tbl[i].st, tbl[i].dr, tbl[i].di, tbl[i].wr, tbl[i].wi);
      end
      chk($sformatf("%s%0d_valid", tag, i), longint'(bus.out_valid), longint'(tbl[i].ev));
      if (tbl[i].cd) begin
        chk($sformatf("%s%0d_dout_r", tag, i), sx(bus.dout_r), tbl[i].er);
        chk($sformatf("%s%0d_dout_i", tag, i), sx(bus.dout_i), tbl[i].ei);
      end
    end
  endtask

  initial begin
    int twr[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
    int twi[8] = '{0, -98, -181, -237, -256, -237, -181, -98};
    int exr[8] = '{-2048, -1896, -1448, -784, 0, 784, 1448, 1896};
    int exi[8] = '{0, 784, 1448, 1896, 2048, 1896, 1448, 784};

    for (int n = 0; n < 16; n++) begin
      tbl[n].iv = 1'b1;
      tbl[n].fl = 1'b0;
      tbl[n].st = (n < 8) ? 2'd0 : 2'd1;
      tbl[n].dr = n * 256;
      tbl[n].di = 0;
      tbl[n].wr = 256;
      tbl[n].wi = 0;
      tbl[n].ev = (n >= 8);
      tbl[n].cd = (n >= 8);
      tbl[n].er = (2 * (n - 8) + 8) * 256;
      tbl[n].ei = 0;
    end
    for (int k = 0; k < 8; k++) begin
      tbl[16+k].iv = 1'b1;
      tbl[16+k].fl = 1'b0;
      tbl[16+k].st = 2'd2;
      tbl[16+k].dr = 0;
      tbl[16+k].di = 0;
      tbl[16+k].wr = twr[k];
      tbl[16+k].wi = twi[k];
      tbl[16+k].ev = 1'b1;
      tbl[16+k].cd = 1'b1;
      tbl[16+k].er = exr[k];
      tbl[16+k].ei = exi[k];
    end

    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.state    = 2'd0;
    bus.din_r    = '0;
    bus.din_i    = '0;
    bus.w_r      = '0;
    bus.w_i      = '0;
    reset        = 1'b1;
    #2;
    do_reset("init");

    // Random traffic, then a mid-stream reset and an idle hold.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom_range(0, 4095),
            $urandom_range(0, 4095), 256, 0);
    end
    do_reset("midrst");
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 2'd1, 'h1000, 'h2000, 256, 0);
      compare_model($sformatf("hold%0d", i));
    end
    // Unit-twiddle reads expose the delay line contents directly.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 2'd2, $urandom_range(1, 999), $urandom_range(1, 999), 256, 0);
      chk($sformatf("zline%0d_r", i), sx(bus.dout_r), 0);
      chk($sformatf("zline%0d_i", i), sx(bus.dout_i), 0);
    end

    do_reset("ramp");
    run_table(1'b0, "ramp");

    do_reset("gap");
    run_table(1'b1, "gap");

    // Round half up: +0.5 goes to 1, -0.5 goes to 0.
    do_reset("rnd");
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 2'd0, (i % 2 == 0) ? 1 : -1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 2'd2, 0, 0, 128, 0);
      chk($sformatf("rnd%0d_r", i), sx(bus.dout_r), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rnd%0d_i", i), sx(bus.dout_i), 0);
    end

    do_reset("ovf");
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 2'd0, 'h7FFFFF, 0, 256, 0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 2'd1, 'h7FFFFF, 0, 256, 0);
`ifdef FFT_SDF_SAT_EN
      chk($sformatf("ovf%0d_r", i), longint'(bus.dout_r), 'h7FFFFF);
`else
      chk($sformatf("ovf%0d_r", i), longint'(bus.dout_r), 'hFFFFFE);
`endif
    end

    do_reset("rand");
    for (int i = 0; i < 400; i++) begin
      bit iv, fl;
      iv = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 3) == 0);
      drive(iv, fl, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
      compare_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
